// File: rtl/alu_sched_pkg.sv
// Shared types for the two-requester ALU scheduler: FSM states, the opcode
// layout, and the logical/arithmetic encoding of opcode bit 3.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       operacion;
    logic [2:0] sel;
  } opcode_t;

  localparam logic OP_LOGIC = 1'b1;
  localparam logic OP_ARITH = 1'b0;

endpackage

// File: rtl/alu_rr_scheduler_rr_arb2.sv
// Combinational 2-way round-robin arbiter. A lone requester always wins; on a
// tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE, drives the ALU for one EXEC cycle, and is held in RESP until consumed.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [N-1:0]  r0_a,
  input  logic [N-1:0]  r0_b,
  input  logic [3:0]    r0_op,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [N-1:0]  r1_a,
  input  logic [N-1:0]  r1_b,
  input  logic [3:0]    r1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [N-1:0]  rsp_data,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_selector1,
  output logic [2:0]    alu_selector2,
  output logic          alu_operacion,
  input  logic [N-1:0]  alu_out,
  output logic [CW-1:0] op_count,
  output state_e        dbg_state
);

  // Every channel transfers on a cycle where valid & ready are both high;
  // valid never depends on ready, and payloads are held while valid waits.

  state_e        state_q;
  logic          last_grant_q;
  logic          id_q;
  logic [N-1:0]  alu_a_q;
  logic [N-1:0]  alu_b_q;
  logic [2:0]    alu_sel1_q;
  logic [2:0]    alu_sel2_q;
  logic          alu_oper_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [N-1:0]  rsp_data_q;
  logic [CW-1:0] op_count_q;

  logic [1:0]    grant;
  logic          in_idle;
  logic          accept;
  logic          gnt_id;
  logic [N-1:0]  sel_a_d;
  logic [N-1:0]  sel_b_d;
  opcode_t       sel_op_d;
  logic [CW-1:0] op_count_d;

  rr_arb2 u_arb (
    .req_i        ({r1_valid, r0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle & (|grant);
  assign gnt_id  = grant[1];

  always_comb begin
    sel_a_d    = gnt_id ? r1_a : r0_a;
    sel_b_d    = gnt_id ? r1_b : r0_b;
    sel_op_d   = opcode_t'(gnt_id ? r1_op : r0_op);
    op_count_d = (&op_count_q) ? op_count_q : op_count_q + CW'(1);
  end

  // The ALU drive registers are loaded on accept and cleared leaving EXEC,
  // so the ALU only sees a non-zero operation during the EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel1_q   <= '0;
      alu_sel2_q   <= '0;
      alu_oper_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            alu_a_q      <= sel_a_d;
            alu_b_q      <= sel_b_d;
            alu_oper_q   <= sel_op_d.operacion;
            alu_sel1_q   <= (sel_op_d.operacion == OP_LOGIC) ? sel_op_d.sel : 3'b000;
            alu_sel2_q   <= (sel_op_d.operacion == OP_ARITH) ? sel_op_d.sel : 3'b000;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_sel1_q  <= '0;
          alu_sel2_q  <= '0;
          alu_oper_q  <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_ready      = in_idle & grant[0];
  assign r1_ready      = in_idle & grant[1];
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_data      = rsp_data_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_selector1 = alu_sel1_q;
  assign alu_selector2 = alu_sel2_q;
  assign alu_operacion = alu_oper_q;
  assign op_count      = op_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with a small ALU stub, directed requests and a
// response scoreboard that also tracks the saturating operation count.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int N    = 8;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [N-1:0]  r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [3:0]    r0_op = '0, r1_op = '0;
  logic          rsp_valid, rsp_id;
  logic          rsp_ready = 1'b1;
  logic [N-1:0]  rsp_data, alu_a, alu_b, alu_out;
  logic [2:0]    alu_selector1, alu_selector2;
  logic          alu_operacion;
  logic [CW-1:0] op_count;
  state_e        dbg_state;

  int            errors = 0;
  int            checks = 0;
  logic [N:0]    exp_q[$];
  int            exp_count = 0;
  bit            armed = 1'b0;
  logic [N:0]    mon_e;
  int            sat_seq[5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_selector1(alu_selector1),
    .alu_selector2(alu_selector2), .alu_operacion(alu_operacion),
    .alu_out(alu_out), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ALU stub: 0000 A+B, 0001 A-B, 1000 A&B, 1001 A|B
  always_comb begin
    alu_out = '0;
    if (alu_operacion) begin
      case (alu_selector1)
        3'd0:    alu_out = alu_a & alu_b;
        3'd1:    alu_out = alu_a | alu_b;
        default: alu_out = '0;
      endcase
    end else begin
      case (alu_selector2)
        3'd0:    alu_out = alu_a + alu_b;
        3'd1:    alu_out = alu_a - alu_b;
        default: alu_out = '0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] op);
    if (id == 0) begin
      r0_valid = v; r0_a = a; r0_b = b; r0_op = op;
    end else begin
      r1_valid = v; r1_a = a; r1_b = b; r1_op = op;
    end
  endtask

  task automatic push_exp(input logic id, input logic [N-1:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_alu_a"}, 32'(alu_a), 0);
    chk({tag, "_alu_b"}, 32'(alu_b), 0);
    chk({tag, "_alu_sel"}, {25'd0, alu_operacion, alu_selector1, alu_selector2}, 0);
    chk({tag, "_ready"}, {30'd0, r1_ready, r0_ready}, 0);
  endtask

  // Issues one request with rsp_ready high and returns once it has been consumed.
  task automatic run_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] op, input logic [N-1:0] expd);
    int k;
    drive_cycle();
    push_exp(id[0], expd);
    set_req(id, 1'b1, a, b, op);
    k = 0;
    sample();
    while (!((id == 0) ? r0_ready : r1_ready) && k < 10) begin
      drive_cycle(); sample(); k++;
    end
    if (k == 10) timeout_fail("run_op_accept");
    drive_cycle();
    set_req(id, 1'b0, a, b, op);
    k = 0;
    sample();
    while (!(rsp_valid && rsp_ready) && k < 20) begin
      drive_cycle(); sample(); k++;
    end
    if (k == 20) timeout_fail("run_op_response");
    drive_cycle();
    sample();
  endtask

  // Scoreboard monitor: checks the count every cycle, pops on each response handshake.
  always @(negedge clk) begin
    if (armed) chk("op_count", 32'(op_count), 32'(exp_count));
    if (rst) begin
      exp_q.delete();
      exp_count = 0;
      armed = 1'b1;
    end else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id_data", 32'({rsp_id, rsp_data}), 32'(mon_e));
      end
      if (exp_count < MAXC) exp_count++;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n, k, prev;

    repeat (2) drive_cycle();
    rst = 1'b0;
    sample();
    chk_idle_outputs("reset");

    // single arithmetic request from r0: 0x12 + 0x34
    drive_cycle();
    push_exp(1'b0, 8'h46);
    set_req(0, 1'b1, 8'h12, 8'h34, 4'b0000);
    sample();
    chk("t1_r0_ready", 32'(r0_ready), 1);
    chk("t1_r1_ready", 32'(r1_ready), 0);
    drive_cycle();
    set_req(0, 1'b0, 8'h12, 8'h34, 4'b0000);
    sample();
    chk("t1_exec_alu_a", 32'(alu_a), 32'h12);
    chk("t1_exec_alu_b", 32'(alu_b), 32'h34);
    chk("t1_exec_sel", {25'd0, alu_operacion, alu_selector1, alu_selector2}, 0);
    chk("t1_exec_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_exec_r0_ready", 32'(r0_ready), 0);
    drive_cycle();
    sample();
    chk("t1_resp_valid", 32'(rsp_valid), 1);
    chk("t1_resp_data", 32'(rsp_data), 32'h46);
    chk("t1_resp_state", 32'(dbg_state), 32'(RESP));
    drive_cycle();
    sample();
    chk("t1_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("t1_rsp_dropped", 32'(rsp_valid), 0);

    // logical OR from r1: 0xF0 | 0x3C
    drive_cycle();
    push_exp(1'b1, 8'hFC);
    set_req(1, 1'b1, 8'hF0, 8'h3C, 4'b1001);
    sample();
    chk("t2_r1_ready", 32'(r1_ready), 1);
    chk("t2_r0_ready", 32'(r0_ready), 0);
    drive_cycle();
    set_req(1, 1'b0, 8'hF0, 8'h3C, 4'b1001);
    sample();
    chk("t2_exec_operacion", 32'(alu_operacion), 1);
    chk("t2_exec_selector1", 32'(alu_selector1), 1);
    chk("t2_exec_selector2", 32'(alu_selector2), 0);
    chk("t2_exec_alu_a", 32'(alu_a), 32'hF0);
    drive_cycle();
    sample();
    chk("t2_resp_id", 32'(rsp_id), 1);
    chk("t2_resp_data", 32'(rsp_data), 32'hFC);
    drive_cycle();
    sample();

    // round robin, both requesters held valid: r0 wins first (last grant was r1)
    drive_cycle();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_exp(1'b0, 8'h0F);
      else            push_exp(1'b1, 8'h08);
    end
    set_req(0, 1'b1, 8'h10, 8'h01, 4'b0001);
    set_req(1, 1'b1, 8'h0C, 8'h0A, 4'b1000);
    n = 0; k = 0; prev = -1;
    while (n < 6 && k < 40) begin
      sample();
      if (r0_ready || r1_ready) begin
        chk("rr_onehot", 32'(r0_ready & r1_ready), 0);
        chk("rr_order", 32'(r1_ready), 32'(n % 2));
        if (prev >= 0) chk("rr_no_repeat", 32'(int'(r1_ready) != prev), 1);
        prev = int'(r1_ready);
        n++;
      end
      k++;
      drive_cycle();
    end
    if (n < 6) timeout_fail("rr_grants");
    set_req(0, 1'b0, 8'h10, 8'h01, 4'b0001);
    set_req(1, 1'b0, 8'h0C, 8'h0A, 4'b1000);
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      sample(); drive_cycle(); k++;
    end
    if (exp_q.size() > 0) timeout_fail("rr_drain");

    // backpressure from a clean count: 5 - 3 = 2, held for 5 RESP cycles
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    rsp_ready = 1'b0;
    push_exp(1'b0, 8'h02);
    set_req(0, 1'b1, 8'h05, 8'h03, 4'b0001);
    sample();
    chk("bp_r0_ready", 32'(r0_ready), 1);
    drive_cycle();
    set_req(0, 1'b0, 8'hFF, 8'hFF, 4'b1001);
    set_req(1, 1'b1, 8'h01, 8'h01, 4'b0000);
    sample();
    chk("bp_exec_alu_a", 32'(alu_a), 32'h05);
    chk("bp_exec_r1_ready", 32'(r1_ready), 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      sample();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_data", 32'(rsp_data), 32'h02);
      chk("bp_hold_ready", {30'd0, r1_ready, r0_ready}, 0);
    end
    drive_cycle();
    rsp_ready = 1'b1;
    set_req(1, 1'b0, 8'h01, 8'h01, 4'b0000);
    sample();
    chk("bp_release_valid", 32'(rsp_valid), 1);
    drive_cycle();
    sample();
    chk("bp_after_state", 32'(dbg_state), 32'(IDLE));
    chk("bp_after_count", 32'(op_count), 1);

    // reset while in EXEC
    drive_cycle();
    set_req(0, 1'b1, 8'h22, 8'h11, 4'b0000);
    sample();
    chk("rx_r0_ready", 32'(r0_ready), 1);
    drive_cycle();
    set_req(0, 1'b0, 8'h22, 8'h11, 4'b0000);
    rst = 1'b1;
    sample();
    chk("rx_in_exec", 32'(dbg_state), 32'(EXEC));
    drive_cycle();
    rst = 1'b0;
    sample();
    chk_idle_outputs("rst_exec");
    chk("rst_exec_count", 32'(op_count), 0);

    // reset while in RESP with the result unconsumed
    rsp_ready = 1'b0;
    drive_cycle();
    set_req(1, 1'b1, 8'h33, 8'h11, 4'b0001);
    sample();
    chk("rr_resp_r1_ready", 32'(r1_ready), 1);
    drive_cycle();
    set_req(1, 1'b0, 8'h33, 8'h11, 4'b0001);
    sample();
    drive_cycle();
    sample();
    chk("rr_resp_valid", 32'(rsp_valid), 1);
    drive_cycle();
    rst = 1'b1;
    sample();
    drive_cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    sample();
    chk_idle_outputs("rst_resp");
    chk("rst_resp_count", 32'(op_count), 0);

    // first tie after reset goes to r0: 0x40 + 0x04
    drive_cycle();
    push_exp(1'b0, 8'h44);
    set_req(0, 1'b1, 8'h40, 8'h04, 4'b0000);
    set_req(1, 1'b1, 8'h50, 8'h05, 4'b0000);
    sample();
    chk("post_rst_r0_ready", 32'(r0_ready), 1);
    chk("post_rst_r1_ready", 32'(r1_ready), 0);
    drive_cycle();
    set_req(0, 1'b0, 8'h40, 8'h04, 4'b0000);
    set_req(1, 1'b0, 8'h50, 8'h05, 4'b0000);
    sample();
    drive_cycle();
    sample();
    chk("post_rst_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'h244);
    drive_cycle();
    sample();
    chk("post_rst_count", 32'(op_count), 1);

    // saturation of the 2-bit count
    drive_cycle();
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    sample();
    chk("sat_start", 32'(op_count), 0);
    for (int i = 0; i < 5; i++) begin
      run_op(0, 8'(i + 1), 8'h01, 4'b0000, 8'(i + 2));
      chk("sat_count", 32'(op_count), 32'(sat_seq[i]));
    end

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
